// File: rtl/pwm_sequencer_if.sv
// Table-write bus and PWM-generator link for pwm_sequencer.
// master = sequencer side, slave = register logic / PWM generator side.
interface pwm_sequencer_if #(
   parameter int AW       = 3,
   parameter int WIDTH    = 4,
   parameter int REPEAT_W = 4
);
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [WIDTH-1:0]    wr_period;
   logic [WIDTH-1:0]    wr_duty;
   logic [REPEAT_W-1:0] wr_repeat;
   logic                period_end;
   logic [WIDTH-1:0]    pwm_period;
   logic [WIDTH-1:0]    pwm_duty;
   logic                pwm_load;
   logic                pwm_start;

   modport master (
      input  wr_en, wr_addr, wr_period, wr_duty, wr_repeat, period_end,
      output pwm_period, pwm_duty, pwm_load, pwm_start
   );
   modport slave (
      output wr_en, wr_addr, wr_period, wr_duty, wr_repeat, period_end,
      input  pwm_period, pwm_duty, pwm_load, pwm_start
   );
endinterface

// File: rtl/pwm_sequencer.sv
// Steps one PWM channel through a table of (period, duty, repeat) entries.
// Optional feature macro: PWM_SEQ_LOOP_EN -- when defined the table replays
// from entry 0 until stopped instead of ending in DONE.
module pwm_sequencer #(
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter int WIDTH    = 4,
   parameter int REPEAT_W = 4
) (
   input  logic          clock,
   input  logic          resetPWM_n,
   pwm_sequencer_if.master bus,
   input  logic [AW:0]   seq_len,
   input  logic          start,
   input  logic          stop,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] cur_index
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, STOPPING, DONE} state_t;

   state_t              state;
   logic [WIDTH-1:0]    period_mem [DEPTH];
   logic [WIDTH-1:0]    duty_mem   [DEPTH];
   logic [REPEAT_W-1:0] rep_mem    [DEPTH];
   logic [AW:0]         len;
   logic [REPEAT_W-1:0] rep_cnt;
   logic [REPEAT_W-1:0] rep_lim;

   logic [WIDTH-1:0]    ent_period;
   logic [WIDTH-1:0]    ent_duty;
   logic [REPEAT_W-1:0] ent_rep;
   logic                last_rep;
   logic                last_entry;

   // Entry fetch with the period>=1, duty<=period, repeat>=1 fix-ups applied.
   always_comb begin
      ent_period = (period_mem[cur_index] == '0) ? WIDTH'(1) : period_mem[cur_index];
      ent_duty   = (duty_mem[cur_index] > ent_period) ? ent_period : duty_mem[cur_index];
      ent_rep    = (rep_mem[cur_index] == '0) ? REPEAT_W'(1) : rep_mem[cur_index];
      last_rep   = ({1'b0, rep_cnt} + (REPEAT_W+1)'(1)) == {1'b0, rep_lim};
      last_entry = ({1'b0, cur_index} + (AW+1)'(1)) >= len;
   end

   // Table storage; writes land in any state, the live entry is latched at LOAD.
   always_ff @(posedge clock or negedge resetPWM_n) begin
      if (!resetPWM_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            period_mem[i] <= '0;
            duty_mem[i]   <= '0;
            rep_mem[i]    <= '0;
         end
      end else if (bus.wr_en) begin
         period_mem[bus.wr_addr] <= bus.wr_period;
         duty_mem[bus.wr_addr]   <= bus.wr_duty;
         rep_mem[bus.wr_addr]    <= bus.wr_repeat;
      end
   end

   // Sequencer FSM; every output is registered alongside the state.
   always_ff @(posedge clock or negedge resetPWM_n) begin
      if (!resetPWM_n) begin
         state          <= IDLE;
         len            <= '0;
         rep_cnt        <= '0;
         rep_lim        <= '0;
         cur_index      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         bus.pwm_period <= '0;
         bus.pwm_duty   <= '0;
         bus.pwm_load   <= 1'b0;
         bus.pwm_start  <= 1'b0;
      end else begin
         bus.pwm_load <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // stop beats a coincident start; empty sequences are ignored
               if (start && !stop && seq_len != '0) begin
                  state     <= LOAD;
                  cur_index <= '0;
                  len       <= seq_len;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            LOAD: begin
               if (stop) begin
                  state <= STOPPING;
               end else begin
                  bus.pwm_period <= ent_period;
                  bus.pwm_duty   <= ent_duty;
                  bus.pwm_load   <= 1'b1;
                  bus.pwm_start  <= 1'b1;
                  rep_cnt        <= '0;
                  rep_lim        <= ent_rep;
                  state          <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  // a period just completed: nothing to truncate, stop now
                  if (bus.period_end) begin
                     state         <= IDLE;
                     bus.pwm_start <= 1'b0;
                     busy          <= 1'b0;
                  end else begin
                     state <= STOPPING;
                  end
               end else if (bus.period_end) begin
                  if (!last_rep) begin
                     rep_cnt <= rep_cnt + REPEAT_W'(1);
                  end else if (!last_entry) begin
                     cur_index <= cur_index + AW'(1);
                     state     <= LOAD;
                  end else begin
`ifdef PWM_SEQ_LOOP_EN
                     cur_index <= '0;
                     state     <= LOAD;
`else
                     state         <= DONE;
                     bus.pwm_start <= 1'b0;
                     busy          <= 1'b0;
                     done          <= 1'b1;
`endif
                  end
               end
            end
            STOPPING: begin
               // let the current period finish before releasing the PWM
               if (bus.period_end) begin
                  state         <= IDLE;
                  bus.pwm_start <= 1'b0;
                  busy          <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: table walk, clamping, stop, ignored
// starts, mid-run reset, and (with PWM_SEQ_LOOP_EN) table replay.
module tb_pwm_sequencer;
   localparam int DEPTH = 8, AW = 3, WIDTH = 4, REPEAT_W = 4;

   logic          clock = 1'b0;
   logic          resetPWM_n;
   logic [AW:0]   seq_len;
   logic          start, stop;
   logic          busy, done;
   logic [AW-1:0] cur_index;
   int            total = 0;
   int            bad   = 0;

   pwm_sequencer_if #(.AW(AW), .WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) bus_if ();

   pwm_sequencer #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) dut (
      .clock      (clock),
      .resetPWM_n (resetPWM_n),
      .bus        (bus_if),
      .seq_len    (seq_len),
      .start      (start),
      .stop       (stop),
      .busy       (busy),
      .done       (done),
      .cur_index  (cur_index)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int a, input int p, input int d, input int r);
      bus_if.wr_en     = 1'b1;
      bus_if.wr_addr   = AW'(a);
      bus_if.wr_period = WIDTH'(p);
      bus_if.wr_duty   = WIDTH'(d);
      bus_if.wr_repeat = REPEAT_W'(r);
      tick();
      bus_if.wr_en = 1'b0;
   endtask

   task automatic pe();
      bus_if.period_end = 1'b1;
      tick();
      bus_if.period_end = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      resetPWM_n = 1'b0;
      seq_len = '0; start = 1'b0; stop = 1'b0;
      bus_if.wr_en = 1'b0; bus_if.wr_addr = '0; bus_if.wr_period = '0;
      bus_if.wr_duty = '0; bus_if.wr_repeat = '0; bus_if.period_end = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_start", bus_if.pwm_start, 0);
      chk("rst_load", bus_if.pwm_load, 0);
      chk("rst_period", bus_if.pwm_period, 0);
      resetPWM_n = 1'b1;
      tick();

`ifdef PWM_SEQ_LOOP_EN
      // table replays 0,1,0,1 with done never set
      wr(0, 5, 1, 1);
      wr(1, 7, 2, 1);
      seq_len = 2;
      go();
      tick();
      chk("lp_idx0", cur_index, 0);
      chk("lp_per0", bus_if.pwm_period, 5);
      pe();
      chk("lp_idx1", cur_index, 1);
      tick();
      chk("lp_per1", bus_if.pwm_period, 7);
      pe();
      chk("lp_idx0b", cur_index, 0);
      chk("lp_done0", done, 0);
      chk("lp_start0", bus_if.pwm_start, 1);
      tick();
      chk("lp_per0b", bus_if.pwm_period, 5);
      pe();
      chk("lp_idx1b", cur_index, 1);
      tick();
      stop = 1'b1;
      pe();
      stop = 1'b0;
      chk("lp_stop_busy", busy, 0);
      chk("lp_stop_done", done, 0);
      chk("lp_stop_start", bus_if.pwm_start, 0);
`else
      // two-entry walk
      wr(0, 10, 5, 2);
      wr(1, 8, 2, 1);
      seq_len = 2;
      go();
      chk("t2_busy_load", busy, 1);
      chk("t2_noload_yet", bus_if.pwm_load, 0);
      tick();
      chk("t2_load0", bus_if.pwm_load, 1);
      chk("t2_per0", bus_if.pwm_period, 10);
      chk("t2_duty0", bus_if.pwm_duty, 5);
      chk("t2_start0", bus_if.pwm_start, 1);
      tick();
      chk("t2_load_pulse", bus_if.pwm_load, 0);
      pe();
      chk("t2_idx_hold", cur_index, 0);
      pe();
      chk("t2_idx1", cur_index, 1);
      chk("t2_start_kept", bus_if.pwm_start, 1);
      tick();
      chk("t2_load1", bus_if.pwm_load, 1);
      chk("t2_per1", bus_if.pwm_period, 8);
      chk("t2_duty1", bus_if.pwm_duty, 2);
      pe();
      chk("t2_done", done, 1);
      chk("t2_start_off", bus_if.pwm_start, 0);
      chk("t2_busy_off", busy, 0);

      // duty clamp and repeat 0 acting as 1
      wr(0, 6, 9, 0);
      seq_len = 1;
      go();
      chk("t3_done_clr", done, 0);
      tick();
      chk("t3_per", bus_if.pwm_period, 6);
      chk("t3_duty_clamp", bus_if.pwm_duty, 6);
      pe();
      chk("t3_done", done, 1);

      // stop waits for period end; a write to the live entry does not disturb it
      wr(0, 12, 3, 3);
      go();
      tick();
      chk("t4_per", bus_if.pwm_period, 12);
      wr(0, 9, 9, 1);
      chk("t4_live_write", bus_if.pwm_period, 12);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t4_stopping_busy", busy, 1);
      chk("t4_stopping_start", bus_if.pwm_start, 1);
      tick();
      chk("t4_still_busy", busy, 1);
      pe();
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_start", bus_if.pwm_start, 0);
      chk("t4_idle_done", done, 0);

      // ignored starts and stray period_end
      seq_len = 0;
      go();
      chk("t5_len0_busy", busy, 0);
      tick();
      chk("t5_len0_load", bus_if.pwm_load, 0);
      seq_len = 1;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tick();
      chk("t5_ss_busy", busy, 0);
      chk("t5_ss_load", bus_if.pwm_load, 0);
      pe();
      chk("t5_pe_idle", busy, 0);

      // reset mid-run, then the cleared table loads as period 1 / duty 0
      go();
      tick();
      chk("t1_run_per", bus_if.pwm_period, 9);
      resetPWM_n = 1'b0;
      #1;
      chk("t1_rst_start", bus_if.pwm_start, 0);
      chk("t1_rst_per", bus_if.pwm_period, 0);
      chk("t1_rst_busy", busy, 0);
      chk("t1_rst_idx", cur_index, 0);
      @(posedge clock);
      #1;
      resetPWM_n = 1'b1;
      tick();
      go();
      tick();
      chk("t1_clr_per", bus_if.pwm_period, 1);
      chk("t1_clr_duty", bus_if.pwm_duty, 0);
      // stop with the final period_end goes straight to IDLE
      stop = 1'b1;
      pe();
      stop = 1'b0;
      chk("sp_busy", busy, 0);
      chk("sp_done", done, 0);
      chk("sp_start", bus_if.pwm_start, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
